// File: rtl/tpu_core_param.sv
// tpu_core_param: parametrised N x N output-stationary MAC array driven by a 16-bit instruction stream.
// Ports: clk, rst_n (async active-low); instr_valid/instr_ready handshake on instruction
// ([15:14] op, [13:11] row, [10:8] col, [7:0] data); result = saturated C[row][col] from the last READ;
// busy high during a RUN sequence; done pulses for one cycle when a RUN completes.
module tpu_core_param #(
  parameter int N = 4,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instruction,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 done
);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic clr;
  logic [7:0] a [N][N];
  logic [7:0] b [N][N];
  logic [ACC_WIDTH-1:0] c [N][N];
  logic [1:0] op;
  logic [2:0] row, col;
  logic [7:0] data;
  logic [KW-1:0] ri, ci;
  logic accept, in_range, start, last;
  logic [ACC_WIDTH-1:0] rd, hi;
  logic signed [ACC_WIDTH-1:0] rs, sh;
  logic [OUT_WIDTH-1:0] sat;
  assign op = instruction[15:14];
  assign row = instruction[13:11];
  assign col = instruction[10:8];
  assign data = instruction[7:0];
  assign ri = row[KW-1:0];
  assign ci = col[KW-1:0];
  assign busy = state == RUN;
  assign done = state == DONE;
  assign instr_ready = ~busy;
  assign accept = instr_valid & instr_ready;
  assign in_range = int'(row) < N && int'(col) < N;
  assign start = accept && op == 2'b11 && !data[1];
  assign last = k == KW'(N - 1);
  // 9-bit extension makes one signed multiplier serve both operand modes.
  function automatic logic [ACC_WIDTH-1:0] mul(input logic [7:0] x, input logic [7:0] y);
    logic signed [17:0] p;
    p = $signed({(SIGNED != 0) && x[7], x}) * $signed({(SIGNED != 0) && y[7], y});
    return ACC_WIDTH'(p);
  endfunction
  // In range when every bit above the result field is a copy of the sign (signed) or zero (unsigned).
  always_comb begin
    rd = in_range ? c[ri][ci] : '0;
    rs = rd;
    sh = rs >>> (OUT_WIDTH - 1);
    hi = (SIGNED != 0) ? sh : rd >> OUT_WIDTH;
    sat = rd[OUT_WIDTH-1:0];
    if (!(hi == '0 || (SIGNED != 0 && hi == '1)))
      sat = (SIGNED != 0) ? {rd[ACC_WIDTH-1], {(OUT_WIDTH-1){~rd[ACC_WIDTH-1]}}} : '1;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      clr <= 1'b0;
      result <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a[i][j] <= '0;
          b[i][j] <= '0;
          c[i][j] <= '0;
        end
    end else begin
      if (state == RUN) begin
        k <= last ? '0 : k + KW'(1);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            c[i][j] <= (clr && k == '0 ? '0 : c[i][j]) + mul(a[i][k], b[k][j]);
      end
      if (accept)
        case (op)
          2'b00: if (in_range) a[ri][ci] <= data;
          2'b01: if (in_range) b[ri][ci] <= data;
          2'b10: result <= sat;
          default: begin
            if (data[1:0] == 2'b10)
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  c[i][j] <= '0;
            if (start) begin
              k <= '0;
              clr <= data[0];
            end
          end
        endcase
    end
  end
endmodule

// File: tb/tb_tpu_core_param.sv
// tb_tpu_core_param: scoreboard bench for tpu_core_param, one unsigned and one signed instance.
module tb_tpu_core_param;
  logic clk = 1'b0;
  logic rst_n;
  logic u_valid, u_ready, u_busy, u_done;
  logic [15:0] u_instr;
  logic [7:0] u_result;
  logic s_valid, s_ready, s_busy, s_done;
  logic [15:0] s_instr;
  logic [7:0] s_result;
  int total = 0;
  int bad = 0;
  logic [7:0] q_u[$];
  logic [7:0] q_s[$];
  logic rd_u = 1'b0;
  logic rd_s = 1'b0;
  always #5 clk = ~clk;
  tpu_core_param #(.N(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(u_valid), .instr_ready(u_ready),
    .instruction(u_instr), .result(u_result), .busy(u_busy), .done(u_done));
  tpu_core_param #(.N(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(s_valid), .instr_ready(s_ready),
    .instruction(s_instr), .result(s_result), .busy(s_busy), .done(s_done));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    rd_u <= rst_n && u_valid && u_ready && u_instr[15:14] == 2'b10;
    rd_s <= rst_n && s_valid && s_ready && s_instr[15:14] == 2'b10;
  end
  always @(negedge clk) begin
    if (rd_u) begin
      if (q_u.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u_read: got %0d expected nothing queued", u_result);
      end else chk("u_read", u_result, q_u.pop_front());
    end
    if (rd_s) begin
      if (q_s.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s_read: got %0d expected nothing queued", s_result);
      end else chk("s_read", s_result, q_s.pop_front());
    end
  end
  function automatic logic [15:0] ins(input logic [1:0] op, input int r, input int c, input logic [7:0] d);
    return {op, 3'(r), 3'(c), d};
  endfunction
  task automatic issue(input bit s, input logic [15:0] x);
    int n = 0;
    @(negedge clk);
    if (s) begin s_instr = x; s_valid = 1'b1; end
    else begin u_instr = x; u_valid = 1'b1; end
    while (!(s ? s_ready : u_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (s) s_valid = 1'b0;
    else u_valid = 1'b0;
  endtask
  task automatic rd(input bit s, input int r, input int c, input logic [7:0] e);
    if (s) q_s.push_back(e);
    else q_u.push_back(e);
    issue(s, ins(2'b10, r, c, 8'd0));
  endtask
  task automatic wait_done(input bit s);
    int n = 0;
    @(negedge clk);
    while (!(s ? s_done : u_done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(n < 30), 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    u_valid = 1'b0; u_instr = '0;
    s_valid = 1'b0; s_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", u_result, 0);
    chk("rst_busy", u_busy, 0);
    chk("rst_done", u_done, 0);
    chk("rst_ready", u_ready, 1);
    rst_n = 1'b1;
    issue(0, ins(2'b00, 0, 0, 8'd2));
    issue(0, ins(2'b01, 0, 0, 8'd3));
    issue(0, ins(2'b11, 0, 0, 8'd1));
    wait_done(0);
    rd(0, 0, 0, 8'd6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", u_result, 0);
    chk("midrst_busy", u_busy, 0);
    chk("midrst_done", u_done, 0);
    chk("midrst_ready", u_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) issue(0, ins(2'b00, i, i, 8'd1));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) issue(0, ins(2'b01, r, c, 8'(4 * r + c + 1)));
    issue(0, ins(2'b11, 0, 0, 8'd1));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("run_busy", u_busy, 1);
      chk("run_ready", u_ready, 0);
      chk("run_done", u_done, 0);
    end
    @(negedge clk);
    chk("fin_done", u_done, 1);
    chk("fin_busy", u_busy, 0);
    chk("fin_ready", u_ready, 1);
    @(negedge clk);
    chk("post_done", u_done, 0);
    rd(0, 2, 3, 8'd12);
    rd(0, 0, 0, 8'd1);
    issue(0, ins(2'b11, 0, 0, 8'd0));
    wait_done(0);
    rd(0, 2, 3, 8'd24);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        issue(0, ins(2'b00, r, c, 8'hFF));
        issue(0, ins(2'b01, r, c, 8'hFF));
      end
    issue(0, ins(2'b11, 0, 0, 8'd1));
    wait_done(0);
    rd(0, 1, 2, 8'd255);
    issue(0, ins(2'b11, 0, 0, 8'd2));
    rd(0, 1, 2, 8'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) issue(0, ins(2'b01, r, c, 8'd0));
    issue(0, ins(2'b01, 0, 0, 8'd1));
    issue(0, ins(2'b11, 0, 0, 8'd0));
    @(negedge clk);
    u_instr = ins(2'b00, 0, 0, 8'd7);
    u_valid = 1'b1;
    chk("hold_blocked", u_ready, 0);
    n = 0;
    while (!u_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wait", n, 4);
    chk("hold_in_done", u_done, 1);
    @(posedge clk);
    #1 u_valid = 1'b0;
    issue(0, ins(2'b00, 5, 0, 8'd9));
    issue(0, ins(2'b11, 0, 0, 8'd1));
    wait_done(0);
    rd(0, 0, 0, 8'd7);
    rd(0, 1, 0, 8'd255);
    rd(0, 4, 0, 8'd0);
    issue(0, ins(2'b11, 0, 0, 8'd1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", u_busy, 0);
    chk("abort_ready", u_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= u_done;
    end
    chk("abort_no_done", seen, 0);
    rd(0, 0, 0, 8'd0);
    rd(0, 1, 0, 8'd0);
    issue(0, ins(2'b00, 0, 0, 8'd3));
    issue(0, ins(2'b01, 0, 0, 8'd5));
    issue(0, ins(2'b11, 0, 0, 8'd1));
    wait_done(0);
    rd(0, 0, 0, 8'd15);
    for (int i = 0; i < 4; i++) begin
      issue(1, ins(2'b00, 0, i, 8'hFE));
      issue(1, ins(2'b01, i, 0, 8'd3));
    end
    issue(1, ins(2'b11, 0, 0, 8'd1));
    wait_done(1);
    rd(1, 0, 0, 8'hE8);
    issue(1, ins(2'b00, 0, 0, 8'h80));
    for (int i = 1; i < 4; i++) issue(1, ins(2'b00, 0, i, 8'd0));
    for (int i = 0; i < 4; i++) issue(1, ins(2'b01, i, 0, 8'h7F));
    issue(1, ins(2'b11, 0, 0, 8'd1));
    wait_done(1);
    rd(1, 0, 0, 8'h80);
    repeat (3) @(negedge clk);
    chk("queues_drained", q_u.size() + q_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
